lsu_dmem_master: RTL

LSU_DMEM_MASTER -- requirements
Module: lsu_dmem_master

---
 rtl/lsu_dmem_master.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_dmem_master.sv
// RV32I load/store unit master for a single-cycle data memory.
// Each request is checked, issued as one ACCESS cycle, then held in RESP until the consumer takes it.
module lsu_dmem_master #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 32'd256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  input  logic [31:0] mem_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [2:0]  F3_B       = 3'd0;
  localparam logic [2:0]  F3_H       = 3'd1;
  localparam logic [2:0]  F3_W       = 3'd2;
  localparam logic [2:0]  F3_BU      = 3'd4;
  localparam logic [2:0]  F3_HU      = 3'd5;
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS) << 2;

  // Offset is taken modulo 2^32 so addresses below BASE_ADDR wrap high and fail the range test.
  function automatic logic access_error(input logic we, input logic [2:0] funct3,
                                        input logic [31:0] addr);
    logic        bad_code;
    logic        misaligned;
    logic [31:0] offset;
    offset = addr - BASE_ADDR;
    case (funct3)
      F3_B:    begin bad_code = 1'b0; misaligned = 1'b0;                end
      F3_H:    begin bad_code = 1'b0; misaligned = addr[0];             end
      F3_W:    begin bad_code = 1'b0; misaligned = (addr[1:0] != 2'b00); end
      F3_BU:   begin bad_code = we;   misaligned = 1'b0;                end
      F3_HU:   begin bad_code = we;   misaligned = addr[0];             end
      default: begin bad_code = 1'b1; misaligned = 1'b0;                end
    endcase
    return bad_code | misaligned | (offset >= SPAN_BYTES);
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3)
      F3_B:    return 4'b0001 << lane;
      F3_H:    return 4'b0011 << lane;
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_wd(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3)
      F3_B:    return {4{wdata[7:0]}};
      F3_H:    return {2{wdata[15:0]}};
      F3_W:    return wdata;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [1:0] lane,
                                              input logic [31:0] rd);
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    case (lane)
      2'd0:    lane_byte = rd[7:0];
      2'd1:    lane_byte = rd[15:8];
      2'd2:    lane_byte = rd[23:16];
      default: lane_byte = rd[31:24];
    endcase
    lane_half = lane[1] ? rd[31:16] : rd[15:0];
    case (funct3)
      F3_B:    return {{24{lane_byte[7]}}, lane_byte};
      F3_H:    return {{16{lane_half[15]}}, lane_half};
      F3_W:    return rd;
      F3_BU:   return {24'h00_0000, lane_byte};
      F3_HU:   return {16'h0000, lane_half};
      default: return 32'h0000_0000;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        mem_active;
  logic        store_active;

  // Next-state logic: request capture in IDLE, response capture at the end of ACCESS.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = access_error(req_we, req_funct3, req_addr);
          state_d  = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        rsp_err_d = err_q;
        if (err_q || we_q) begin
          rsp_rdata_d = 32'h0000_0000;
        end else begin
          rsp_rdata_d = load_extend(funct3_q, addr_q[1:0], mem_rd);
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request/response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      err_q       <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // rst gates the memory strobes combinationally so a reset landing in ACCESS cannot write.
  assign mem_active   = (state_q == ACCESS) && !rst && !err_q;
  assign store_active = mem_active && we_q;

  assign req_ready = (state_q == IDLE) && !rst;
  assign mem_addr  = mem_active ? {addr_q[31:2], 2'b00} : 32'h0000_0000;
  assign mem_we    = store_active;
  assign mem_be    = store_active ? store_be(funct3_q, addr_q[1:0]) : 4'b0000;
  assign mem_wd    = store_active ? store_wd(funct3_q, wdata_q) : 32'h0000_0000;
  assign rsp_valid = (state_q == RESP) && !rst;
  assign rsp_rdata = rst ? 32'h0000_0000 : rsp_rdata_q;
  assign rsp_err   = rsp_err_q && !rst;

endmodule
